// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: fetch/decode/execute/memory/writeback over one shared memory port.
// Optional performance counters (cycleCnt, instret) are enabled by defining MULTICYCLE_PERF_CNT_EN.
module multicycle_ctrl #(
  parameter bit RESET_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       validInst,
  input  logic       branch,
  input  logic [1:0] jump,
  input  logic       memRead,
  input  logic       memWrite,
  input  logic       regWrite,
  input  logic       branchTaken,
  input  logic       haltReq,
  input  logic       memGnt,
  input  logic       memRvalid,
  output logic       memReq,
  output logic       memWe,
  output logic       memAddrSel,
  output logic       irWrite,
  output logic       pcWrite,
  output logic [1:0] pcSel,
  output logic       rfWe,
  output logic       illegal,
  output logic       halted,
  output logic [2:0] state
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [31:0] cycleCnt,
  output logic [31:0] instret
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_FWAIT  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_MWAIT  = 3'd5,
    S_WB     = 3'd6,
    S_TRAP   = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic       illegal_q;
  logic       hold_q, hold_d;
  logic       req_c, we_c, sel_c, ir_c, pcw_c, rfwe_c, halt_c;
  logic [1:0] pcs_c;

  // hold_q keeps the core parked in FETCH after reset (RESET_HALT=1) until haltReq is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      hold_q    <= RESET_HALT;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == S_TRAP);
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    req_c   = 1'b0;
    we_c    = 1'b0;
    sel_c   = 1'b0;
    ir_c    = 1'b0;
    pcw_c   = 1'b0;
    pcs_c   = 2'b00;
    rfwe_c  = 1'b0;
    halt_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (!haltReq) hold_d = 1'b0;
        if (haltReq || hold_q) begin
          halt_c = 1'b1;
        end else begin
          req_c = 1'b1;
          if (memGnt) state_d = S_FWAIT;
        end
      end
      S_FWAIT: begin
        if (memRvalid) begin
          ir_c    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = validInst ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (memRead || memWrite) begin
          state_d = S_MEM;
        end else if (branch) begin
          pcw_c   = 1'b1;
          pcs_c   = branchTaken ? 2'b01 : 2'b00;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // A load+store combination is treated as a load, so memWe stays low.
        req_c = 1'b1;
        sel_c = 1'b1;
        we_c  = memWrite & ~memRead;
        if (memGnt) state_d = S_MWAIT;
      end
      S_MWAIT: begin
        if (memRvalid) begin
          if (memRead) begin
            state_d = S_WB;
          end else begin
            pcw_c   = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        rfwe_c  = regWrite;
        pcw_c   = 1'b1;
        pcs_c   = (jump == 2'b11) ? 2'b10 : (jump == 2'b01) ? 2'b01 : 2'b00;
        state_d = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase
  end

  assign memReq     = rst_n & req_c;
  assign memWe      = rst_n & we_c;
  assign memAddrSel = sel_c;
  assign irWrite    = rst_n & ir_c;
  assign pcWrite    = rst_n & pcw_c;
  assign pcSel      = pcs_c;
  assign rfWe       = rst_n & rfwe_c;
  assign illegal    = illegal_q;
  assign halted     = rst_n ? halt_c : RESET_HALT;
  assign state      = state_q;

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instret_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_q <= 32'd0;
      instret_q   <= 32'd0;
    end else begin
      if (state_q != S_TRAP && !halt_c) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (pcw_c) instret_q <= instret_q + 32'd1;
    end
  end

  assign cycleCnt = cycle_cnt_q;
  assign instret  = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a per-instruction expected cycle trace is built from the
// sequencing rules and compared cycle by cycle while a random-latency memory answers requests.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       validInst, branch, memRead, memWrite, regWrite, branchTaken;
  logic [1:0] jump;
  logic       haltReq, memGnt, memRvalid;
  logic       memReq, memWe, memAddrSel, irWrite, pcWrite, rfWe, illegal, halted;
  logic [1:0] pcSel;
  logic [2:0] state;
`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycleCnt, instret;
  int unsigned exp_cyc, exp_ret;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .validInst(validInst), .branch(branch), .jump(jump),
    .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite), .branchTaken(branchTaken),
    .haltReq(haltReq), .memGnt(memGnt), .memRvalid(memRvalid), .memReq(memReq), .memWe(memWe),
    .memAddrSel(memAddrSel), .irWrite(irWrite), .pcWrite(pcWrite), .pcSel(pcSel), .rfWe(rfWe),
    .illegal(illegal), .halted(halted), .state(state)
`ifdef MULTICYCLE_PERF_CNT_EN
    , .cycleCnt(cycleCnt), .instret(instret)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Trace vector: {state[2:0], illegal, halted, memReq, memWe, memAddrSel, irWrite, pcWrite, pcSel[1:0], rfWe}
  logic [12:0] exp_q[$];

  function automatic logic [12:0] mk(input logic [2:0] st, input logic ill, input logic hlt,
                                     input logic req, input logic we, input logic sel,
                                     input logic ir, input logic pcw, input logic [1:0] pcs,
                                     input logic rf);
    return {st, ill, hlt, req, we, sel, ir, pcw, pcs, rf};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {state, illegal, halted, memReq, memReq & memWe, memReq & memAddrSel, irWrite,
            pcWrite, pcWrite ? pcSel : 2'b00, rfWe};
  endfunction

  // Current instruction's decode and the memory latencies used for it.
  logic       v_valid, v_branch, v_rd, v_wr, v_rw, v_taken;
  logic [1:0] v_jump;
  int         gf, rf_d, gd, rd, nhalt;

  // Memory responder state.
  bit req_seen, rv_pending;
  int g_cnt, rv_cnt;

  task automatic respond();
    memGnt    = 1'b0;
    memRvalid = 1'b0;
    if (rv_pending) begin
      if (rv_cnt == 0) begin
        memRvalid  = 1'b1;
        rv_pending = 1'b0;
      end else rv_cnt--;
    end else memRvalid = 1'($urandom_range(0, 1));
    if (memReq) begin
      if (!req_seen) begin
        req_seen = 1'b1;
        g_cnt    = memAddrSel ? gd : gf;
      end
      if (g_cnt == 0) begin
        memGnt     = 1'b1;
        req_seen   = 1'b0;
        rv_pending = 1'b1;
        rv_cnt     = memAddrSel ? rd : rf_d;
      end else g_cnt--;
    end else memGnt = 1'($urandom_range(0, 1));
  endtask

  task automatic step(input logic hreq);
    @(negedge clk);
    validInst = v_valid; branch = v_branch; jump = v_jump; memRead = v_rd;
    memWrite = v_wr; regWrite = v_rw; branchTaken = v_taken; haltReq = hreq;
    #1;
    respond();
    #1;
  endtask

  // Expected trace of one instruction from the sequencing rules and the chosen latencies.
  task automatic build_expect();
    logic [1:0] wb_sel;
    for (int i = 0; i < nhalt; i++) exp_q.push_back(mk(3'd0, 0, 1, 0, 0, 0, 0, 0, 2'd0, 0));
    for (int i = 0; i <= gf; i++) exp_q.push_back(mk(3'd0, 0, 0, 1, 0, 0, 0, 0, 2'd0, 0));
    for (int i = 0; i < rf_d; i++) exp_q.push_back(mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    exp_q.push_back(mk(3'd1, 0, 0, 0, 0, 0, 1, 0, 2'd0, 0));
    exp_q.push_back(mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    wb_sel = (v_jump == 2'b11) ? 2'd2 : (v_jump == 2'b01) ? 2'd1 : 2'd0;
    if (!v_valid) begin
      exp_q.push_back(mk(3'd7, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    end else if (v_rd || v_wr) begin
      exp_q.push_back(mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
      for (int i = 0; i <= gd; i++)
        exp_q.push_back(mk(3'd4, 0, 0, 1, v_wr & ~v_rd, 1, 0, 0, 2'd0, 0));
      for (int i = 0; i < rd; i++) exp_q.push_back(mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
      if (v_rd) begin
        exp_q.push_back(mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
        exp_q.push_back(mk(3'd6, 0, 0, 0, 0, 0, 0, 1, wb_sel, v_rw));
      end else begin
        exp_q.push_back(mk(3'd5, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0));
      end
    end else if (v_branch) begin
      exp_q.push_back(mk(3'd3, 0, 0, 0, 0, 0, 0, 1, {1'b0, v_taken}, 0));
    end else begin
      exp_q.push_back(mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
      exp_q.push_back(mk(3'd6, 0, 0, 0, 0, 0, 0, 1, wb_sel, v_rw));
    end
  endtask

  task automatic drain(input string name);
    logic [12:0] e;
    logic        hreq;
    int          idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      // haltReq only matters in FETCH; elsewhere it toggles freely.
      hreq = e[8] ? 1'b1 : ((e[12:10] == 3'd0) ? 1'b0 : 1'($urandom_range(0, 1)));
      step(hreq);
      check_eq($sformatf("%s.c%0d", name, idx), 32'(obs_vec()), 32'(e));
`ifdef MULTICYCLE_PERF_CNT_EN
      check_eq($sformatf("%s.cyc%0d", name, idx), cycleCnt, exp_cyc);
      check_eq($sformatf("%s.ret%0d", name, idx), instret, exp_ret);
      if (!e[8] && e[12:10] != 3'd7) exp_cyc++;
      if (e[3]) exp_ret++;
`endif
      idx++;
    end
  endtask

  task automatic run_inst(input string name, input logic val, input logic br, input logic [1:0] jmp,
                          input logic lrd, input logic lwr, input logic rw, input logic tk);
    v_valid = val; v_branch = br; v_jump = jmp; v_rd = lrd; v_wr = lwr; v_rw = rw; v_taken = tk;
    build_expect();
    drain(name);
  endtask

  task automatic do_reset(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      rst_n   = 1'b0;
      haltReq = 1'($urandom_range(0, 1));
      #1;
      respond();
      #1;
      check_eq("rst.memReq", 32'(memReq), 32'd0);
      check_eq("rst.strobes", 32'({memWe, irWrite, pcWrite, rfWe}), 32'd0);
      check_eq("rst.halted", 32'(halted), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1; haltReq = 1'b0; memGnt = 1'b0; memRvalid = 1'b0;
    req_seen = 1'b0; rv_pending = 1'b0;
    #2;
    check_eq("rst.state", 32'(state), 32'd0);
    check_eq("rst.illegal", 32'(illegal), 32'd0);
`ifdef MULTICYCLE_PERF_CNT_EN
    check_eq("rst.cycleCnt", cycleCnt, 32'd0);
    check_eq("rst.instret", instret, 32'd0);
    exp_cyc = 1;
    exp_ret = 0;
`endif
  endtask

  task automatic trap_and_reset(input string name);
    for (int i = 0; i < 20; i++) exp_q.push_back(mk(3'd7, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    drain(name);
    do_reset(1);
  endtask

  initial begin
    rst_n = 1'b0; haltReq = 1'b0; memGnt = 1'b0; memRvalid = 1'b0;
    v_valid = 1'b1; v_branch = 1'b0; v_jump = 2'b00; v_rd = 1'b0; v_wr = 1'b0;
    v_rw = 1'b0; v_taken = 1'b0;
    validInst = 1'b1; branch = 1'b0; jump = 2'b00; memRead = 1'b0; memWrite = 1'b0;
    regWrite = 1'b0; branchTaken = 1'b0;
    req_seen = 1'b0; rv_pending = 1'b0; g_cnt = 0; rv_cnt = 0;
    gf = 0; rf_d = 0; gd = 0; rd = 0; nhalt = 0;
    do_reset(3);

    // Zero-wait memory directed cases.
    run_inst("add", 1, 0, 2'b00, 0, 0, 1, 0);
    gd = 3;
    run_inst("lw_gnt3", 1, 0, 2'b00, 1, 0, 1, 0);
    gd = 0;
    run_inst("beq_t", 1, 1, 2'b00, 0, 0, 0, 1);
    run_inst("beq_nt", 1, 1, 2'b00, 0, 0, 0, 0);
    run_inst("jalr", 1, 0, 2'b11, 0, 0, 1, 0);
    run_inst("jal", 1, 0, 2'b01, 0, 0, 1, 0);
    run_inst("jump10", 1, 0, 2'b10, 0, 0, 1, 0);
    run_inst("sw", 1, 0, 2'b00, 0, 1, 0, 0);
    run_inst("ld_st", 1, 0, 2'b00, 1, 1, 1, 0);
    nhalt = 3;
    run_inst("halt_add", 1, 0, 2'b00, 0, 0, 1, 0);
    nhalt = 0;
    run_inst("illegal", 0, 0, 2'b00, 0, 0, 0, 0);
    trap_and_reset("trap");

    // Random instruction mix with random memory latencies and halts.
    for (int n = 0; n < 80; n++) begin
      gf    = $urandom_range(0, 3);
      rf_d  = $urandom_range(0, 3);
      gd    = $urandom_range(0, 3);
      rd    = $urandom_range(0, 3);
      nhalt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_inst($sformatf("rnd%0d", n), 1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (!v_valid) trap_and_reset($sformatf("rnd%0d.trap", n));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I core. Drives fetch, decode, execute, memory and writeback one instruction at a time, sharing a single memory port between instruction fetch and load/store.
- Consumes the decoder's control outputs and the ALU compare result.
- Generates PC, IR, register-file and memory strobes.
- Sits between the decoder/ALU datapath and the unified memory interface.

Parameters:
- RESET_HALT, 0, when 1 the controller leaves reset in halted FETCH (no memReq) until haltReq deasserts.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- validInst  in  1  decoder: opcode recognised.
- branch  in  1  decoder: conditional branch.
- jump  in  2  decoder: 00 none, 01 PC-relative (JAL), 11 register (JALR); 10 treated as 00.
- memRead  in  1  decoder: load.
- memWrite  in  1  decoder: store.
- regWrite  in  1  decoder: instruction writes rd.
- branchTaken  in  1  ALU compare result, valid in EXEC.
- haltReq  in  1  debug halt, sampled only in FETCH.
- memGnt  in  1  memory accepted current request.
- memRvalid  in  1  read data valid / write ack.
- memReq  out  1  memory request.
- memWe  out  1  write enable qualifying memReq.
- memAddrSel  out  1  0 = PC, 1 = ALU result.
- irWrite  out  1  latch memory data into IR.
- pcWrite  out  1  update PC.
- pcSel  out  2  00 PC+4, 01 PC+imm, 10 ALU result (low bit cleared by datapath).
- rfWe  out  1  register-file write strobe.
- illegal  out  1  sticky illegal-instruction flag.
- halted  out  1  controller idle in FETCH due to haltReq.
- state  out  3  current state encoding, for debug.

Behaviour:
- States (encoding): FETCH=0, FWAIT=1, DECODE=2, EXEC=3, MEM=4, MWAIT=5, WB=6, TRAP=7.
- Reset:
  - rst_n low at a rising edge: state<=FETCH, illegal<=0.
  - While rst_n is low, all strobes (memReq, memWe, irWrite, pcWrite, rfWe) are forced 0. halted=RESET_HALT.
- FETCH:
  - haltReq=1: memReq=0, halted=1, stay.
  - Otherwise: memReq=1, memAddrSel=0, memWe=0. memGnt=1 moves to FWAIT; else hold request stable.
- FWAIT: wait for memRvalid. On memRvalid, irWrite=1 in that cycle, then go to DECODE.
- DECODE: validInst=0 goes to TRAP; otherwise EXEC.
- EXEC:
  - memRead|memWrite: go to MEM.
  - branch: pcWrite=1, pcSel=branchTaken?01:00, then FETCH.
  - Otherwise: go to WB.
- MEM: memReq=1, memAddrSel=1, memWe=memWrite. memGnt moves to MWAIT.
- MWAIT, on memRvalid:
  - Load: go to WB.
  - Store: pcWrite=1, pcSel=00, then FETCH.
- WB:
  - rfWe=regWrite.
  - pcWrite=1, with pcSel=10 if jump==11, 01 if jump==01, else 00.
  - Then FETCH.
- TRAP: illegal=1 (set on entry, sticky). No requests or writes. Exit only via reset.
- Handshake rules:
  - memReq, memWe and memAddrSel remain constant from assertion until the cycle memGnt is seen.
  - memRvalid is ignored outside FWAIT/MWAIT.
  - memGnt is ignored when memReq=0.
- Output timing: strobes are combinational from state plus same-cycle inputs. Exactly one of irWrite/pcWrite/rfWe-group per state as listed; no strobe outside its state.
- Latency with zero-wait memory (gnt same cycle as req, rvalid next cycle):
  - ALU op / JAL / JALR: 5 cycles.
  - Branch: 4 cycles.
  - Store: 6 cycles.
  - Load: 7 cycles.
- memWrite together with memRead: treated as load (memWe=0 in MEM).
- haltReq outside FETCH has no effect until the next FETCH.

Optional Feature:
- Macro MULTICYCLE_PERF_CNT_EN adds two outputs, cycleCnt[31:0] and instret[31:0], both cleared by reset.
  - cycleCnt increments every cycle except while in TRAP or halted.
  - instret increments on each cycle with pcWrite=1.
  - Both wrap 0xFFFFFFFF to 0.
- Without the macro, neither the ports nor the counters exist.

Test Plan:
- ADD (regWrite=1), zero-wait memory -> states 0,1,2,3,6,0. irWrite in cycle 2, rfWe=1 and pcWrite=1 with pcSel=00 in cycle 5.
- LW, memGnt delayed 3 cycles in MEM -> memReq/memAddrSel=1/memWe=0 held 4 cycles. Then MWAIT, WB rfWe=1, total 10 cycles.
- BEQ with branchTaken=1 then =0 -> pcWrite in EXEC with pcSel=01, then 00. rfWe never asserted.
- JALR (jump=11, regWrite=1) -> WB asserts rfWe=1, pcSel=10. SW -> memWe=1 in MEM, pcSel=00 in MWAIT on memRvalid, no rfWe.
- validInst=0 -> TRAP (state=7), illegal=1, no memReq for 20 cycles. rst_n low for one edge -> state=0, illegal=0.
- haltReq=1 in FETCH -> halted=1, memReq=0. Deassert -> memReq=1 next cycle. With the macro enabled, cycleCnt stays frozen during halt.
